// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, bus widths and PPROT bit positions.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int APB_AW = 32;
    localparam int APB_DW = 32;
    localparam int APB_SW = APB_DW / 8;

    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

endpackage

// File: rtl/apb_regfile_bank.sv
// NUM_REGS x 32-bit register storage: one byte-enabled write port, one combinational
// read port. Register 0 always reads back the fixed ID value.
module apb_regfile_bank
    import apb_pkg::*;
#(
    parameter int              NUM_REGS = 16,
    parameter int              IDX_W    = 4,
    parameter logic [APB_DW-1:0] ID_VALUE = 32'hA0B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [APB_DW-1:0] i_wdata,
    input  logic [APB_SW-1:0] i_wstrb,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [APB_DW-1:0] o_rdata
);

    logic [NUM_REGS-1:0][APB_DW-1:0] r_mem;
    logic                            w_ridx_ok;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_mem <= '0;
        end else if (i_we) begin
            for (int b = 0; b < APB_SW; b++) begin
                if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Guards non-power-of-two banks against indices past the last register.
    assign w_ridx_ok = ({1'b0, i_ridx} < (IDX_W+1)'(NUM_REGS));

    always_comb begin
        o_rdata = '0;
        if (i_ridx == '0)   o_rdata = ID_VALUE;
        else if (w_ridx_ok) o_rdata = r_mem[i_ridx];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer: wait-state FSM, address decode and PSLVERR generation in front of
// a small control/status register bank.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                NUM_REGS    = 16,
    parameter logic [APB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int                WAIT_CYCLES = 2,
    parameter logic [APB_DW-1:0] ID_VALUE    = 32'hA0B0_0001
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic              PWRITE,
    input  logic [APB_DW-1:0] PWDATA,
    input  logic [APB_SW-1:0] PSTRB,
    input  logic [2:0]        PPROT,
    input  logic              PNSE,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    apb_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [APB_AW-1:0] r_addr;
    logic              r_write;
    logic [APB_DW-1:0] r_wdata;
    logic [APB_SW-1:0] r_strb;
    logic [2:0]        r_prot;
    logic              r_nse;

    logic [APB_AW-1:0] w_off;
    logic [IDX_W-1:0]  w_idx;
    logic              w_err;
    logic              w_ready;
    logic              w_we;
    logic [APB_DW-1:0] w_rdata;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_wdata <= '0;
            r_strb  <= '0;
            r_prot  <= '0;
            r_nse   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (PSELx && !PENABLE) begin
                        r_addr  <= PADDR;
                        r_write <= PWRITE;
                        r_wdata <= PWDATA;
                        r_strb  <= PSTRB;
                        r_prot  <= PPROT;
                        r_nse   <= PNSE;
                        r_cnt   <= CNT_W'(WAIT_CYCLES);
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Deselect mid-transfer aborts; PENABLE low just stalls the count.
                    if (!PSELx) begin
                        r_state <= IDLE;
                    end else if (PENABLE) begin
                        if (r_cnt != '0) r_cnt   <= r_cnt - 1'b1;
                        else             r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Decode works on the captured fields only, keeping PADDR/PWDATA off the output paths.
    assign w_off = r_addr - BASE_ADDR;
    assign w_idx = w_off[IDX_W+1:2];

    always_comb begin
        w_err = 1'b0;
        if (w_off >= APB_AW'(NUM_REGS * 4))                         w_err = 1'b1;
        if (r_addr[1:0] != 2'b00)                                   w_err = 1'b1;
        if (r_nse)                                                  w_err = 1'b1;
        if (r_write && (w_idx == '0))                               w_err = 1'b1;
        if (r_write && !r_prot[PPROT_PRIV] &&
            ({1'b0, w_idx} >= (IDX_W+1)'(NUM_REGS / 2)))            w_err = 1'b1;
    end

    assign w_ready = (r_state == ACCESS) && (r_cnt == '0) && PSELx && PENABLE;
    assign w_we    = w_ready && r_write && !w_err;

    apb_regfile_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .i_we    (w_we),
        .i_widx  (w_idx),
        .i_wdata (r_wdata),
        .i_wstrb (r_strb),
        .i_ridx  (w_idx),
        .o_rdata (w_rdata)
    );

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && w_err;
    assign PRDATA  = (w_ready && !r_write && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: two instances (2 and 0 wait states) on a
// shared bus, checked against an array-based register model.
module tb_apb_slave_regfile;

    localparam logic [31:0] ID = 32'hA0B0_0001;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        psel0, psel1;
    logic        PENABLE, PWRITE, PNSE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int nvec = 0;
    int nerr = 0;
    logic [31:0] mdl [2][16];

    always #5 PCLK = ~PCLK;

    apb_slave_regfile #(.WAIT_CYCLES(2)) u_dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel0), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PNSE(PNSE), .PRDATA(prdata0), .PREADY(pready0),
        .PSLVERR(pslverr0)
    );

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel1), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PNSE(PNSE), .PRDATA(prdata1), .PREADY(pready1),
        .PSLVERR(pslverr1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic exp_err(input logic wr, input logic [31:0] addr,
                                     input logic [2:0] prot, input logic nse);
        logic [31:0] off;
        off = addr;  // base address is 0
        if (off >= 64)                          return 1'b1;
        if (addr % 4 != 0)                      return 1'b1;
        if (nse)                                return 1'b1;
        if (wr && off / 4 == 0)                 return 1'b1;
        if (wr && off / 4 >= 8 && !prot[0])     return 1'b1;
        return 1'b0;
    endfunction

    task automatic bus_idle();
        @(posedge PCLK); #1;
        psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("idle_ctl", {28'd0, pready0, pslverr0, pready1, pslverr1}, 32'd0);
        chk("idle_rd", prdata0 | prdata1, 32'd0);
    endtask

    // One APB transfer; leaves PSEL/PENABLE asserted so the next SETUP can follow directly.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                        input logic nse, output logic [31:0] rd, output logic er, output int lat);
        logic done;
        @(posedge PCLK); #1;
        psel0 = (d == 0); psel1 = (d == 1); PENABLE = 1'b0;
        PWRITE = wr; PADDR = addr; PWDATA = wd; PSTRB = strb; PPROT = prot; PNSE = nse;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = 1; done = 1'b0; rd = '0; er = 1'b0;
        while (!done && lat < 20) begin
            @(negedge PCLK);
            if ((d == 0) ? pready0 : pready1) begin
                done = 1'b1;
                rd = (d == 0) ? prdata0 : prdata1;
                er = (d == 0) ? pslverr0 : pslverr1;
            end else begin
                @(posedge PCLK); #1;
                lat++;
            end
        end
        if (!done) begin
            chk("timeout", 32'd0, 32'd1);
            lat = -1;
        end
    endtask

    task automatic run(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] strb, input logic [2:0] prot,
                       input logic nse, input string tag);
        logic [31:0] rd, erd;
        logic        er, eerr;
        int          lat, idx;
        eerr = exp_err(wr, addr, prot, nse);
        idx  = int'(addr >> 2);
        erd  = '0;
        if (!eerr && !wr) erd = (idx == 0) ? ID : mdl[d][idx];
        xfer(d, wr, addr, wd, strb, prot, nse, rd, er, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(1 + wait_of(d)));
        chk({tag, "_err"}, {31'd0, er}, {31'd0, eerr});
        if (!wr) chk({tag, "_rd"}, rd, erd);
        if (!eerr && wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) mdl[d][i] = '0;
        PRESETn = 1'b0; psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0; PNSE = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("rst_ctl", {28'd0, pready0, pslverr0, pready1, pslverr1}, 32'd0);
        chk("rst_rd", prdata0 | prdata1, 32'd0);
        @(posedge PCLK); #1;
        PRESETn = 1'b1;

        // Directed scenarios
        run(0, 1'b0, 32'h0,  32'h0,         4'h0, 3'b000, 1'b0, "id_rd");
        bus_idle();
        run(0, 1'b1, 32'h4,  32'h1122_3344, 4'b0101, 3'b000, 1'b0, "strb_wr");
        run(0, 1'b0, 32'h4,  32'h0,         4'h0, 3'b000, 1'b0, "strb_rd");
        chk("strb_val", mdl[0][1], 32'h0022_0044);
        run(0, 1'b0, 32'h40, 32'h0,         4'h0, 3'b000, 1'b0, "oor_rd");
        run(0, 1'b1, 32'h2,  32'hFFFF_FFFF, 4'hF, 3'b001, 1'b0, "misal_wr");
        run(0, 1'b1, 32'h0,  32'h1234_5678, 4'hF, 3'b001, 1'b0, "r0_wr");
        run(0, 1'b0, 32'h0,  32'h0,         4'h0, 3'b000, 1'b0, "r0_rd");
        run(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b0, "prot_wr0");
        run(0, 1'b0, 32'h20, 32'h0,         4'h0, 3'b000, 1'b0, "prot_rd0");
        run(0, 1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, 3'b001, 1'b0, "prot_wr1");
        run(0, 1'b0, 32'h20, 32'h0,         4'h0, 3'b000, 1'b0, "prot_rd1");
        run(0, 1'b1, 32'h8,  32'h5555_AAAA, 4'h0, 3'b000, 1'b0, "nostrb_wr");
        run(0, 1'b1, 32'h8,  32'h0BAD_F00D, 4'hF, 3'b000, 1'b1, "nse_wr");
        run(0, 1'b0, 32'h8,  32'h0,         4'h0, 3'b000, 1'b0, "nse_rd");
        bus_idle();

        // Abort a write to 0x8 during its wait count
        @(posedge PCLK); #1;
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8;
        PWDATA = 32'hFFFF_FFFF; PSTRB = 4'hF; PPROT = 3'b001; PNSE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        chk("abort_rdy_a", {31'd0, pready0}, 32'd0);
        @(posedge PCLK); #1;
        psel0 = 1'b0; PENABLE = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            chk("abort_rdy_b", {31'd0, pready0}, 32'd0);
        end
        run(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000, 1'b0, "abort_rd");
        bus_idle();

        // Zero wait states, back-to-back
        run(1, 1'b1, 32'hC, 32'hCAFE_0123, 4'hF, 3'b000, 1'b0, "b2b_wr");
        run(1, 1'b0, 32'hC, 32'h0,         4'h0, 3'b000, 1'b0, "b2b_rd");
        chk("b2b_val", mdl[1][3], 32'hCAFE_0123);
        bus_idle();

        // Randomized traffic on both instances
        for (int n = 0; n < 300; n++) begin
            int          d, r;
            logic [31:0] a;
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'($urandom_range(0, 63));
            else             a = 32'(4 * $urandom_range(0, 17));
            run(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                3'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0), "rnd");
            if ($urandom_range(0, 2) == 0) bus_idle();
        end
        bus_idle();

        // Final sweep: every register of both instances read back against the model
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++)
                run(d, 1'b0, 32'(4 * i), 32'h0, 4'h0, 3'b000, 1'b0, "sweep");
        bus_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
